// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

   localparam int FIFO_MODE_STD  = 32'sd0;
   localparam int FIFO_MODE_FWFT = 32'sd1;

   function automatic int ptr_width(input int depth);
      if (depth > 32'sd1) begin
         return $clog2(depth);
      end else begin
         return 32'sd1;
      end
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus of the synchronous FIFO; master drives requests, slave is the FIFO.
interface sync_fifo_if #(
   parameter int WIDTH = 32'sd16,
   parameter int CW    = 32'sd4
);
   logic             flush;
   logic [WIDTH-1:0] data_in;
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] data_out;
   logic             rd_valid;
   logic [CW-1:0]    count;
   logic             wr_ack;
   logic             overflow;
   logic             underflow;
   logic             full;
   logic             empty;
   logic             almostfull;
   logic             almostempty;

   modport master (
      output flush, data_in, wr_en, rd_en,
      input  data_out, rd_valid, count, wr_ack, overflow, underflow,
      input  full, empty, almostfull, almostempty
   );

   modport slave (
      input  flush, data_in, wr_en, rd_en,
      output data_out, rd_valid, count, wr_ack, overflow, underflow,
      output full, empty, almostfull, almostempty
   );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = 32'sd16,
   parameter int DEPTH = 32'sd8,
   parameter int AW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, occupancy count,
// synchronous flush and selectable registered or first-word-fall-through read.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int  FIFO_WIDTH = 32'sd16,
   parameter int  FIFO_DEPTH = 32'sd8,
   parameter int  AF_LEVEL   = FIFO_DEPTH - 32'sd1,
   parameter int  AE_LEVEL   = 32'sd1,
   parameter int  FWFT       = FIFO_MODE_STD,
   localparam int CW         = $clog2(FIFO_DEPTH + 32'sd1)
) (
   input logic        clk,
   input logic        rst,
   sync_fifo_if.slave bus
);

   localparam int AW = ptr_width(FIFO_DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 32'sd1);

   if (FIFO_WIDTH < 32'sd1) begin : g_width_chk
      $fatal(1, "sync_fifo_param: FIFO_WIDTH must be >= 1");
   end
   if (FIFO_DEPTH < 32'sd2) begin : g_depth_chk
      $fatal(1, "sync_fifo_param: FIFO_DEPTH must be >= 2");
   end
   if ((AF_LEVEL < 32'sd1) || (AF_LEVEL > FIFO_DEPTH)) begin : g_af_chk
      $fatal(1, "sync_fifo_param: AF_LEVEL outside 1..FIFO_DEPTH");
   end
   if ((AE_LEVEL < 32'sd0) || (AE_LEVEL > FIFO_DEPTH - 32'sd1)) begin : g_ae_chk
      $fatal(1, "sync_fifo_param: AE_LEVEL outside 0..FIFO_DEPTH-1");
   end
   if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_mode_chk
      $fatal(1, "sync_fifo_param: FWFT must be 0 or 1");
   end

   logic [AW-1:0]         wr_ptr_r;
   logic [AW-1:0]         rd_ptr_r;
   logic [AW-1:0]         wr_ptr_nxt_s;
   logic [AW-1:0]         rd_ptr_nxt_s;
   logic [CW-1:0]         count_r;
   logic [FIFO_WIDTH-1:0] head_s;
   logic [FIFO_WIDTH-1:0] dout_r;
   logic                  full_s;
   logic                  empty_s;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic                  rd_valid_r;
   logic                  wr_ack_r;
   logic                  overflow_r;
   logic                  underflow_r;

   assign full_s  = (count_r == CW'(FIFO_DEPTH));
   assign empty_s = (count_r == CW'(32'sd0));

   // Accept decisions; a flush cycle swallows both requests
   always_comb begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
      if (!bus.flush) begin
         wr_acc_s = bus.wr_en && !full_s;
         rd_acc_s = bus.rd_en && !empty_s;
      end else begin
         wr_acc_s = 1'b0;
         rd_acc_s = 1'b0;
      end
   end

   // Explicit wrap keeps non-power-of-two depths inside the array
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (wr_ptr_r == LAST_PTR) begin
         wr_ptr_nxt_s = '0;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r + AW'(32'sd1);
      end
      if (rd_ptr_r == LAST_PTR) begin
         rd_ptr_nxt_s = '0;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r + AW'(32'sd1);
      end
   end

   // Pointers, occupancy, status pulses and registered read data
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         rd_valid_r  <= 1'b0;
         wr_ack_r    <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         dout_r      <= '0;
      end else if (bus.flush) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         rd_valid_r  <= 1'b0;
         wr_ack_r    <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_nxt_s;
         end
         if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_nxt_s;
            dout_r   <= head_s;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_r <= count_r + CW'(32'sd1);
            2'b01:   count_r <= count_r - CW'(32'sd1);
            default: count_r <= count_r;
         endcase
         rd_valid_r  <= rd_acc_s;
         wr_ack_r    <= wr_acc_s;
         overflow_r  <= bus.wr_en && full_s;
         underflow_r <= bus.rd_en && empty_s;
      end
   end

   sync_fifo_mem #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc_s),
      .waddr (wr_ptr_r),
      .wdata (bus.data_in),
      .raddr (rd_ptr_r),
      .rdata (head_s)
   );

   assign bus.data_out    = (FWFT == FIFO_MODE_FWFT) ? head_s   : dout_r;
   assign bus.rd_valid    = (FWFT == FIFO_MODE_FWFT) ? !empty_s : rd_valid_r;
   assign bus.count       = count_r;
   assign bus.wr_ack      = wr_ack_r;
   assign bus.overflow    = overflow_r;
   assign bus.underflow   = underflow_r;
   assign bus.full        = full_s;
   assign bus.empty       = empty_s;
   assign bus.almostfull  = (count_r >= CW'(AF_LEVEL));
   assign bus.almostempty = (count_r <= CW'(AE_LEVEL));

endmodule
